wb_merge_stage: RTL and testbench

WB_MERGE_STAGE -- requirements
Module: wb_merge_stage

---
 rtl/wb_pkg.sv | 6 +
 rtl/wb_age_arbiter.sv | 38 +++
 rtl/wb_merge_stage.sv | 112 +++++++++++
 tb/tb_wb_merge_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared defaults and limits for the write-back merge stage
package wb_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int MAX_CH = 8;
endpackage

// File: rtl/wb_age_arbiter.sv
// wb_age_arbiter: oldest-first grant over occupied slots using an age matrix
module wb_age_arbiter #(
  parameter int N = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic [N-1:0]        occ_i,
  input  logic [N-1:0]        acc_i,
  output logic [N-1:0]        gnt_o,
  output logic [N-1:0][N-1:0] age_o
);
  logic [N-1:0][N-1:0] age_q, age_d;
  logic [N-1:0] occ_nxt;
  // age_q[i][j] set means slot i was accepted before slot j; grant the slot older than every other occupant
  always_comb begin
    gnt_o = occ_i;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (i != j && occ_i[j] && !age_q[i][j]) gnt_o[i] = 1'b0;
  end
  // new entries become youngest (same-edge entries ordered by index); bits of empty slots are cleared
  always_comb begin
    occ_nxt = flush_i ? '0 : (occ_i & ~gnt_o) | acc_i;
    age_d = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (i != j)
          age_d[i][j] = occ_nxt[i] & occ_nxt[j] &
                        (acc_i[i] ? (acc_i[j] && (i < j)) : (acc_i[j] | age_q[i][j]));
  end
  // age matrix register
  always_ff @(posedge clk) begin
    if (!rst_n) age_q <= '0;
    else age_q <= age_d;
  end
  assign age_o = age_q;
endmodule

// File: rtl/wb_merge_stage.sv
// wb_merge_stage: merges per-channel results into one register-file write port with forwarding
module wb_merge_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_CH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic [NUM_CH-1:0]        ch_valid_i,
  output logic [NUM_CH-1:0]        ch_ready_o,
  input  logic [NUM_CH-1:0]        ch_we_i,
  input  logic [NUM_CH*ADDR_W-1:0] ch_waddr_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  output logic [DATA_W-1:0]        wb_op_c_o,
  output logic [ADDR_W-1:0]        wb_reg_waddr_o,
  output logic                     wb_reg_we_o,
  input  logic [ADDR_W-1:0]        fwd_raddr_i,
  output logic                     fwd_hit_o,
  output logic [DATA_W-1:0]        fwd_data_o
);
  logic [NUM_CH-1:0] occ_q, occ_d, fill, gnt, match, youngest;
  logic [NUM_CH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_CH-1:0][DATA_W-1:0] data_q, data_d;
  logic [NUM_CH-1:0][NUM_CH-1:0] age;
  logic [DATA_W-1:0] op_q, op_d, slot_fwd;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic we_q, we_d, out_hit;

  wb_age_arbiter #(.N(NUM_CH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .occ_i   (occ_q),
    .acc_i   (fill),
    .gnt_o   (gnt),
    .age_o   (age)
  );

  // accept when the slot is free or draining this cycle; only real register writes occupy a slot
  always_comb begin
    ch_ready_o = '0;
    fill = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_ready_o[k] = rst_n & ~flush_i & (~occ_q[k] | gnt[k]);
      fill[k] = ch_valid_i[k] & ch_ready_o[k] & ch_we_i[k] & (ch_waddr_i[k*ADDR_W +: ADDR_W] != '0);
    end
  end

  // slot next state and output register load from the granted slot
  always_comb begin
    occ_d = flush_i ? '0 : (occ_q & ~gnt) | fill;
    addr_d = addr_q;
    data_d = data_q;
    we_d = !flush_i && (gnt != '0);
    op_d = op_q;
    waddr_d = waddr_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (fill[k]) begin
        addr_d[k] = ch_waddr_i[k*ADDR_W +: ADDR_W];
        data_d[k] = ch_data_i[k*DATA_W +: DATA_W];
      end
      if (we_d && gnt[k]) begin
        op_d = data_q[k];
        waddr_d = addr_q[k];
      end
    end
  end

  // slot and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q <= 1'b0;
      op_q <= '0;
      waddr_q <= '0;
    end else begin
      occ_q <= occ_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_q <= we_d;
      op_q <= op_d;
      waddr_q <= waddr_d;
    end
  end

  // forwarding: youngest matching slot first, then the output register
  always_comb begin
    match = '0;
    youngest = '0;
    slot_fwd = '0;
    for (int i = 0; i < NUM_CH; i++)
      match[i] = occ_q[i] && (fwd_raddr_i != '0) && (addr_q[i] == fwd_raddr_i);
    for (int i = 0; i < NUM_CH; i++) begin
      youngest[i] = match[i];
      for (int j = 0; j < NUM_CH; j++)
        if (i != j && match[j] && !age[j][i]) youngest[i] = 1'b0;
      if (youngest[i]) slot_fwd = slot_fwd | data_q[i];
    end
    out_hit = we_q && (fwd_raddr_i != '0) && (waddr_q == fwd_raddr_i);
    fwd_hit_o = (match != '0) || out_hit;
    fwd_data_o = (match != '0) ? slot_fwd : out_hit ? op_q : '0;
  end

  assign wb_op_c_o = op_q;
  assign wb_reg_waddr_o = waddr_q;
  assign wb_reg_we_o = we_q;
endmodule

// File: tb/tb_wb_merge_stage.sv
// tb_wb_merge_stage: directed stimulus with a write-port scoreboard and inline ready/forwarding checks
module tb_wb_merge_stage;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [2:0] valid, we, ready;
  logic [14:0] waddr;
  logic [95:0] data;
  logic [31:0] op, fdata;
  logic [4:0] waddr_o, fraddr;
  logic we_o, hit;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t;

  typedef struct {
    logic [4:0] a;
    logic [31:0] d;
    int c;
  } exp_t;
  exp_t q[$];
  exp_t e;

  wb_merge_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .ch_valid_i     (valid),
    .ch_ready_o     (ready),
    .ch_we_i        (we),
    .ch_waddr_i     (waddr),
    .ch_data_i      (data),
    .wb_op_c_o      (op),
    .wb_reg_waddr_o (waddr_o),
    .wb_reg_we_o    (we_o),
    .fwd_raddr_i    (fraddr),
    .fwd_hit_o      (hit),
    .fwd_data_o     (fdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int ch, input logic w, input logic [4:0] a, input logic [31:0] d);
    valid[ch] = 1'b1;
    we[ch] = w;
    waddr[ch*5 +: 5] = a;
    data[ch*32 +: 32] = d;
  endtask

  task automatic idle();
    valid = '0;
    we = '0;
    flush = 1'b0;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d, input int c);
    q.push_back('{a, d, c});
  endtask

  always @(negedge clk) begin
    if (we_o) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0h data=%0h cycle=%0d required=no write", waddr_o, op, cyc);
      end else begin
        e = q.pop_front();
        chk("wb_addr", 64'(waddr_o), 64'(e.a));
        chk("wb_data", 64'(op), 64'(e.d));
        chk("wb_cycle", 64'(cyc), 64'(e.c));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    waddr = '0;
    data = '0;
    fraddr = '0;
    step();
    step();
    chk("reset_ready", 64'(ready), 64'h0);
    chk("reset_we", 64'(we_o), 64'h0);
    chk("reset_data", 64'(op), 64'h0);
    chk("reset_addr", 64'(waddr_o), 64'h0);
    rst_n = 1'b1;
    #1;
    chk("post_reset_ready", 64'(ready), 64'h7);

    step();
    t = cyc;
    send(0, 1'b1, 5'd5, 32'hA5A5_0001);
    expect_wr(5'd5, 32'hA5A5_0001, t + 2);
    step();
    idle();
    fraddr = 5'd5;
    #1;
    chk("single_fwd_slot_hit", 64'(hit), 64'h1);
    chk("single_fwd_slot_data", 64'(fdata), 64'hA5A5_0001);
    step();
    chk("single_fwd_out_hit", 64'(hit), 64'h1);
    chk("single_fwd_out_data", 64'(fdata), 64'hA5A5_0001);
    step();
    chk("single_we_drop", 64'(we_o), 64'h0);
    chk("single_data_hold", 64'(op), 64'hA5A5_0001);
    chk("single_fwd_gone", 64'(hit), 64'h0);

    step();
    t = cyc;
    send(0, 1'b1, 5'd3, 32'h11);
    send(2, 1'b1, 5'd4, 32'h22);
    expect_wr(5'd3, 32'h11, t + 2);
    expect_wr(5'd4, 32'h22, t + 3);
    step();
    idle();
    #1;
    chk("collide_ready_wait", 64'(ready), 64'h3);
    step();
    chk("collide_ready_drain", 64'(ready), 64'h7);
    step();
    step();

    t = cyc;
    send(0, 1'b1, 5'd8, 32'h88);
    send(2, 1'b1, 5'd9, 32'h99);
    expect_wr(5'd8, 32'h88, t + 2);
    expect_wr(5'd9, 32'h99, t + 3);
    step();
    idle();
    send(1, 1'b1, 5'd7, 32'h1);
    expect_wr(5'd7, 32'h1, t + 4);
    step();
    idle();
    send(0, 1'b1, 5'd7, 32'h2);
    #1;
    chk("order_ch0_ready", 64'(ready[0]), 64'h1);
    expect_wr(5'd7, 32'h2, t + 5);
    step();
    idle();
    fraddr = 5'd7;
    #1;
    chk("order_fwd_hit", 64'(hit), 64'h1);
    chk("order_fwd_youngest", 64'(fdata), 64'h2);
    step();
    chk("order_fwd_slot_over_out", 64'(fdata), 64'h2);
    step();
    chk("order_fwd_out", 64'(fdata), 64'h2);
    step();
    step();

    send(0, 1'b1, 5'd0, 32'hFF);
    #1;
    chk("filter_x0_ready", 64'(ready), 64'h7);
    step();
    idle();
    send(0, 1'b0, 5'd5, 32'hFF);
    #1;
    chk("filter_we0_ready", 64'(ready), 64'h7);
    step();
    idle();
    fraddr = 5'd5;
    #1;
    chk("filter_ready_after", 64'(ready), 64'h7);
    chk("filter_no_fwd", 64'(hit), 64'h0);
    step();
    step();
    chk("filter_no_write", 64'(we_o), 64'h0);

    send(0, 1'b1, 5'd1, 32'h101);
    send(1, 1'b1, 5'd2, 32'h102);
    send(2, 1'b1, 5'd3, 32'h103);
    step();
    idle();
    fraddr = 5'd2;
    #1;
    chk("flush_pre_hit", 64'(hit), 64'h1);
    chk("flush_pre_data", 64'(fdata), 64'h102);
    flush = 1'b1;
    #1;
    chk("flush_ready_low", 64'(ready), 64'h0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_ready_after", 64'(ready), 64'h7);
    chk("flush_no_we", 64'(we_o), 64'h0);
    for (int a = 1; a <= 3; a++) begin
      fraddr = 5'(a);
      #1;
      chk("flush_fwd_miss", 64'(hit), 64'h0);
    end
    step();
    step();

    send(0, 1'b1, 5'd10, 32'hAA);
    send(1, 1'b1, 5'd11, 32'hBB);
    step();
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready", 64'(ready), 64'h0);
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_mid_we", 64'(we_o), 64'h0);
    chk("rst_mid_data", 64'(op), 64'h0);
    chk("rst_mid_addr", 64'(waddr_o), 64'h0);
    fraddr = 5'd10;
    #1;
    chk("rst_mid_fwd10", 64'(hit), 64'h0);
    fraddr = 5'd11;
    #1;
    chk("rst_mid_fwd11", 64'(hit), 64'h0);
    for (int i = 0; i < 5; i++) step();

    chk("scoreboard_empty", 64'(q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
